// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared types and constants for the multiply/divide unit.
//   op_t         decoded HI/LO-class operation presented by the execute stage
//   mdu_state_t  controller FSM state
//   DIV_STEPS    iteration count of the radix-2 divider
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        OpNone, OpMult, OpMultu, OpDiv, OpDivu, OpMthi, OpMtlo,
        OpMfhi, OpMflo, OpMul, OpMadd, OpMaddu, OpMsub, OpMsubu
    } op_t;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} mdu_state_t;

    localparam int unsigned DIV_STEPS = 32;

    // Ops whose multiplier operands are treated as two's complement.
    function automatic logic op_is_signed(op_t op);
        return op inside {OpMult, OpMul, OpMadd, OpMsub};
    endfunction

    // Accumulating multiply family (optional in the build).
    function automatic logic op_is_acc(op_t op);
        return op inside {OpMadd, OpMaddu, OpMsub, OpMsubu};
    endfunction

endpackage

// File: rtl/mdu_ctrl_div.sv
// mdu_div: restoring radix-2 divider, one quotient bit per cycle.
//   clk, reset   clock, synchronous active-high reset
//   start        load operands (b must be non-zero)
//   a, b         dividend, divisor
//   is_signed    treat a/b as two's complement
//   kill         abandon the running division
//   busy         division in progress
//   q, r         signed-corrected quotient/remainder, valid while valid=1
//   valid        final step is being computed this cycle; results are
//                taken on the edge that ends it, 32 cycles after start
module mdu_div
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    input  logic        kill,
    output logic        busy,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        valid
);

    logic [31:0] rem_q, quo_q, dvs_q;
    logic [4:0]  cnt_q;
    logic        busy_q, neg_q_q, neg_r_q;

    logic [32:0] shifted, diff;
    logic [31:0] rem_n, quo_n;
    logic [31:0] mag_a, mag_b;

    assign mag_a = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign mag_b = (is_signed && b[31]) ? (~b + 32'd1) : b;

    // One restoring step: try subtracting the divisor from the shifted remainder.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[32]) begin
            rem_n = diff[31:0];
            quo_n = {quo_q[30:0], 1'b1};
        end else begin
            rem_n = shifted[31:0];
            quo_n = {quo_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || kill) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= mag_a;
            dvs_q   <= mag_b;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            neg_q_q <= is_signed && (a[31] ^ b[31]);
            neg_r_q <= is_signed && a[31];
        end else if (busy_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_STEPS - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy  = busy_q;
    assign valid = busy_q && (cnt_q == 5'(DIV_STEPS - 1));
    assign q     = neg_q_q ? (~quo_n + 32'd1) : quo_n;
    assign r     = neg_r_q ? (~rem_n + 32'd1) : rem_n;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller owning architectural HI/LO.
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready op handshake (ready only when idle)
//   in_op, in_a, in_b decoded op and rs/rt operands, latched at accept
//   flush             kill any in-flight op; beats same-cycle accept/completion
//   busy, done        not idle / one-cycle completion strobe
//   mul_res           low product of MUL, valid while done
//   unsup             strobe: accepted op not built into this configuration
//   hi, lo            architectural HI/LO
// Build option: define MDU_MADD_EN to execute MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  op_t         in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] mul_res,
    output logic        unsup,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  state_q, state_d;
    op_t         op_q;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, mul_res_q, mul_res_d;
    logic        unsup_q, unsup_d;

    logic        accept, mul_class, is_div, mul_start, div_start;
    logic [63:0] a_ext, b_ext, prod, prod_last;
    logic [63:0] prod_q [MUL_LAT];
    logic [MUL_LAT-1:0] mvld_q;
    logic        mul_fin;
    logic        div_busy, div_valid;
    logic [31:0] div_q, div_r;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
`ifdef MDU_MADD_EN
        mul_class = (in_op inside {OpMult, OpMultu, OpMul}) || op_is_acc(in_op);
`else
        mul_class = in_op inside {OpMult, OpMultu, OpMul};
`endif
    end

    assign is_div    = in_op inside {OpDiv, OpDivu};
    assign mul_start = accept && mul_class;
    assign div_start = accept && is_div && (in_b != 32'd0);

    // Low 64 bits of the extended product are correct for both signednesses.
    assign a_ext = {{32{op_is_signed(in_op) & in_a[31]}}, in_a};
    assign b_ext = {{32{op_is_signed(in_op) & in_b[31]}}, in_b};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mvld_q <= '0;
        end else begin
            mvld_q[0] <= mul_start;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                mvld_q[i] <= mvld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_q[0] <= prod;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign prod_last = prod_q[MUL_LAT-1];
    assign mul_fin   = (state_q == StMul) && mvld_q[MUL_LAT-1];

    mdu_div u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .a         (in_a),
        .b         (in_b),
        .is_signed (in_op == OpDiv),
        .kill      (flush),
        .busy      (div_busy),
        .q         (div_q),
        .r         (div_r),
        .valid     (div_valid)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_res_d = mul_res_q;
        unsup_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (mul_class) begin
                        state_d = StMul;
                    end else if (is_div) begin
                        state_d = (in_b != 32'd0) ? StDiv : StDone;
                    end else if (in_op == OpMthi) begin
                        hi_d    = in_a;
                        state_d = StDone;
                    end else if (in_op == OpMtlo) begin
                        lo_d    = in_a;
                        state_d = StDone;
                    end
`ifndef MDU_MADD_EN
                    else if (op_is_acc(in_op)) begin
                        unsup_d = 1'b1;
                    end
`endif
                end
            end
            StMul: begin
                if (mul_fin) begin
                    state_d = StDone;
                    case (op_q)
                        OpMul: mul_res_d = prod_last[31:0];
`ifdef MDU_MADD_EN
                        OpMadd, OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod_last;
                        OpMsub, OpMsubu: {hi_d, lo_d} = {hi_q, lo_q} - prod_last;
`endif
                        default: {hi_d, lo_d} = prod_last;
                    endcase
                end
            end
            StDiv: begin
                if (div_valid) begin
                    state_d = StDone;
                    lo_d    = div_q;
                    hi_d    = div_r;
                end else if (!div_busy) begin
                    // Divider lost its operation; never strand the pipeline.
                    state_d = StIdle;
                end
            end
            StDone: state_d = StIdle;
        endcase
        if (flush) begin
            state_d   = StIdle;
            hi_d      = hi_q;
            lo_d      = lo_q;
            mul_res_d = mul_res_q;
            unsup_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= OpNone;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_res_q <= '0;
            unsup_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mul_res_q <= mul_res_d;
            unsup_q   <= unsup_d;
            if (accept) begin
                op_q <= in_op;
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign mul_res = mul_res_q;
    assign unsup   = unsup_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl (directed cases plus random
// ops checked against an arithmetic reference model of HI/LO).
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    op_t         in_op = OpNone;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        flush = 1'b0;
    logic        busy, done, unsup;
    logic [31:0] mul_res, hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .mul_res  (mul_res),
        .unsup    (unsup),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Reference: architectural effect of one op on {HI,LO}.
    function automatic void model_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] mh, inout logic [31:0] ml,
                                     output bit e_done, output int e_lat, output bit e_unsup,
                                     output logic [31:0] e_mul);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] p;
        e_done = 1'b0; e_lat = 0; e_unsup = 1'b0; e_mul = 32'd0;
        case (op)
            OpMult:  begin p = sa * sb; {mh, ml} = p; e_done = 1; e_lat = MUL_LAT + 1; end
            OpMultu: begin p = ua * ub; {mh, ml} = p; e_done = 1; e_lat = MUL_LAT + 1; end
            OpMul:   begin p = sa * sb; e_mul = p[31:0]; e_done = 1; e_lat = MUL_LAT + 1; end
            OpMadd, OpMaddu, OpMsub, OpMsubu: begin
`ifdef MDU_MADD_EN
                p = (op inside {OpMadd, OpMsub}) ? sa * sb : ua * ub;
                if (op inside {OpMadd, OpMaddu}) {mh, ml} = {mh, ml} + p;
                else {mh, ml} = {mh, ml} - p;
                e_done = 1; e_lat = MUL_LAT + 1;
`else
                e_unsup = 1;
`endif
            end
            OpDiv: begin
                e_done = 1;
                if (b == 0) e_lat = 1;
                else begin ml = 32'(sa / sb); mh = 32'(sa % sb); e_lat = 33; end
            end
            OpDivu: begin
                e_done = 1;
                if (b == 0) e_lat = 1;
                else begin ml = a / b; mh = a % b; e_lat = 33; end
            end
            OpMthi: begin mh = a; e_done = 1; e_lat = 1; end
            OpMtlo: begin ml = a; e_done = 1; e_lat = 1; end
            default: ;
        endcase
    endfunction

    // Present one op at the next edge, then watch up to budget cycles.
    task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int budget, output int lat, output bit seen_done,
                         output int ucount, output logic [31:0] o_mul);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        lat = 0; seen_done = 0; ucount = 0; o_mul = 'x;
        for (int c = 1; c <= budget; c++) begin
            if (unsup) ucount++;
            if (done) begin
                seen_done = 1; lat = c; o_mul = mul_res;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks += 7;
        if (hi !== 32'd0)    begin failures++; $display("FAIL reset_hi got=%h want=0", hi); end
        if (lo !== 32'd0)    begin failures++; $display("FAIL reset_lo got=%h want=0", lo); end
        if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        if (unsup !== 1'b0)  begin failures++; $display("FAIL reset_unsup got=%b want=0", unsup); end
        if (mul_res !== 0)   begin failures++; $display("FAIL reset_mulres got=%h want=0", mul_res); end
        if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (in_ready !== 1)  begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        m_hi = 0; m_lo = 0;
    endtask

    typedef struct {
        op_t         op;
        logic [31:0] a, b, ehi, elo, emul;
        int          elat;
    } vec_t;

    task automatic test_directed();
        vec_t v [8];
        int lat, uc;
        bit sd;
        logic [31:0] om;
        v[0] = '{OpMult,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 4};
        v[1] = '{OpMultu, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 32'd0, 4};
        v[2] = '{OpDiv,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0, 33};
        v[3] = '{OpDivu,  32'd7,        32'd2, 32'd1,        32'd3,        32'd0, 33};
        v[4] = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'd0,  32'h80000000, 32'd0, 33};
        v[5] = '{OpMtlo,  32'h1234,     32'd0, 32'd0,        32'h1234,     32'd0, 1};
        v[6] = '{OpDivu,  32'd5,        32'd0, 32'd0,        32'h1234,     32'd0, 1};
        v[7] = '{OpMul,   32'd3, 32'hFFFFFFFB, 32'd0,        32'h1234, 32'hFFFFFFF1, 4};
        for (int i = 0; i < 8; i++) begin
            issue(v[i].op, v[i].a, v[i].b, 40, lat, sd, uc, om);
            checks += 4;
            if (!sd) begin failures++; $display("FAIL dir%0d_done got=0 want=1", i); end
            if (lat != v[i].elat) begin
                failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, v[i].elat);
            end
            if (hi !== v[i].ehi) begin failures++; $display("FAIL dir%0d_hi got=%h want=%h", i, hi, v[i].ehi); end
            if (lo !== v[i].elo) begin failures++; $display("FAIL dir%0d_lo got=%h want=%h", i, lo, v[i].elo); end
            if (v[i].op == OpMul) begin
                checks++;
                if (om !== v[i].emul) begin
                    failures++; $display("FAIL dir%0d_mulres got=%h want=%h", i, om, v[i].emul);
                end
            end
            @(posedge clk); #1;
            checks += 2;
            if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_width got=1 want=0", i); end
            if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_ready got=0 want=1", i); end
            m_hi = v[i].ehi; m_lo = v[i].elo;
        end
    endtask

    task automatic test_madd();
        int lat, uc;
        bit sd;
        logic [31:0] om;
        issue(OpMthi, 32'd0, 32'd0, 5, lat, sd, uc, om);
        @(posedge clk); #1;
        issue(OpMtlo, 32'hFFFFFFFF, 32'd0, 5, lat, sd, uc, om);
        @(posedge clk); #1;
`ifdef MDU_MADD_EN
        issue(OpMaddu, 32'd1, 32'd1, 10, lat, sd, uc, om);
        checks += 4;
        if (!sd || lat != MUL_LAT + 1) begin
            failures++; $display("FAIL maddu_done got=%0d/%0d want=1/%0d", sd, lat, MUL_LAT + 1);
        end
        if (hi !== 32'd1) begin failures++; $display("FAIL maddu_hi got=%h want=1", hi); end
        if (lo !== 32'd0) begin failures++; $display("FAIL maddu_lo got=%h want=0", lo); end
        if (uc != 0) begin failures++; $display("FAIL maddu_unsup got=%0d want=0", uc); end
        @(posedge clk); #1;
        m_hi = 32'd1; m_lo = 32'd0;
`else
        issue(OpMaddu, 32'd1, 32'd1, 6, lat, sd, uc, om);
        checks += 5;
        if (uc != 1) begin failures++; $display("FAIL maddu_unsup_pulses got=%0d want=1", uc); end
        if (sd) begin failures++; $display("FAIL maddu_done got=1 want=0"); end
        if (hi !== 32'd0) begin failures++; $display("FAIL maddu_hi got=%h want=0", hi); end
        if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL maddu_lo got=%h want=ffffffff", lo); end
        if (busy !== 1'b0) begin failures++; $display("FAIL maddu_busy got=1 want=0"); end
        m_hi = 32'd0; m_lo = 32'hFFFFFFFF;
`endif
    endtask

    task automatic test_flush();
        int lat, uc;
        bit sd, saw;
        logic [31:0] om;
        // Flush a divide 10 cycles in.
        in_valid = 1'b1; in_op = OpDiv; in_a = 32'd100; in_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        saw = 0;
        for (int c = 1; c < 10; c++) begin
            if (done) saw = 1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks += 4;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_div_idle got=busy%b/ready%b want=0/1", busy, in_ready);
        end
        if (saw || done) begin failures++; $display("FAIL flush_div_done got=1 want=0"); end
        if (hi !== m_hi) begin failures++; $display("FAIL flush_div_hi got=%h want=%h", hi, m_hi); end
        if (lo !== m_lo) begin failures++; $display("FAIL flush_div_lo got=%h want=%h", lo, m_lo); end
        issue(OpMthi, 32'hA5A5A5A5, 32'd0, 5, lat, sd, uc, om);
        checks += 2;
        if (!sd || lat != 1) begin failures++; $display("FAIL mthi_after_flush_lat got=%0d want=1", lat); end
        if (hi !== 32'hA5A5A5A5) begin failures++; $display("FAIL mthi_after_flush_hi got=%h want=a5a5a5a5", hi); end
        m_hi = 32'hA5A5A5A5;
        @(posedge clk); #1;
        // Flush beats a same-cycle accept.
        in_valid = 1'b1; in_op = OpMtlo; in_a = 32'hDEADBEEF; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks += 2;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL flush_accept_state got=busy%b want=0", busy); end
        if (lo !== m_lo) begin failures++; $display("FAIL flush_accept_lo got=%h want=%h", lo, m_lo); end
        // Flush beats a same-cycle multiply completion.
        in_valid = 1'b1; in_op = OpMult; in_a = 32'd9; in_b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (MUL_LAT - 1) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks += 2;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_complete_state got=done%b busy%b want=0/0", done, busy); end
        if (hi !== m_hi || lo !== m_lo) begin
            failures++; $display("FAIL flush_complete_hilo got=%h_%h want=%h_%h", hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        bit saw;
        in_valid = 1'b1; in_op = OpMult; in_a = 32'h1234567; in_b = 32'h89;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) saw = 1;
            @(posedge clk); #1;
        end
        checks += 3;
        if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_mid_hilo got=%h_%h want=0_0", hi, lo); end
        if (saw) begin failures++; $display("FAIL reset_mid_done got=1 want=0"); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=1 want=0"); end
        m_hi = 0; m_lo = 0;
    endtask

    function automatic logic [31:0] pick_operand();
        unique case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int lat, uc, e_lat;
        bit sd, e_done, e_unsup;
        logic [31:0] om, e_mul, a, b;
        op_t op;
        for (int n = 0; n < 60; n++) begin
            op = op_t'($urandom_range(0, 13));
            a = pick_operand(); b = pick_operand();
            model_op(op, a, b, m_hi, m_lo, e_done, e_lat, e_unsup, e_mul);
            issue(op, a, b, e_done ? e_lat + 2 : 3, lat, sd, uc, om);
            checks += 4;
            if (sd != e_done) begin failures++; $display("FAIL rnd%0d_%s_done got=%0d want=%0d", n, op.name(), sd, e_done); end
            if (e_done && lat != e_lat) begin
                failures++; $display("FAIL rnd%0d_%s_lat got=%0d want=%0d", n, op.name(), lat, e_lat);
            end
            if (uc != int'(e_unsup)) begin failures++; $display("FAIL rnd%0d_%s_unsup got=%0d want=%0d", n, op.name(), uc, e_unsup); end
            if (hi !== m_hi || lo !== m_lo) begin
                failures++;
                $display("FAIL rnd%0d_%s_hilo a=%h b=%h got=%h_%h want=%h_%h", n, op.name(), a, b, hi, lo, m_hi, m_lo);
            end
            if (op == OpMul) begin
                checks++;
                if (om !== e_mul) begin failures++; $display("FAIL rnd%0d_mulres got=%h want=%h", n, om, e_mul); end
            end
            if (sd) begin @(posedge clk); #1; end
            checks++;
            if (in_ready !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_%s_idle got=ready%b done%b want=1/0", n, op.name(), in_ready, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_madd();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the MIPS core. Accepts decoded HI/LO-class ops (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MUL, plus MADD/MADDU/MSUB/MSUBU when enabled) from the execute stage. Sequences a fixed-latency multiplier and a 32-step iterative divider, and owns the architectural HI/LO registers. Raises `busy` so the pipeline stalls dependent instructions.

## Interface
- MUL_LAT, 3, multiplier pipeline depth in cycles (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  op presented
- in_ready  out  1  block can accept; high only in IDLE
- in_op  in  op_t  decoded op
- in_a  in  32  rs value
- in_b  in  32  rt value
- flush  in  1  exception/abort; kills in-flight op
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion strobe
- mul_res  out  32  low product of MUL; valid while done
- unsup  out  1  one-cycle strobe: accepted op not supported by this build
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Accept on the rising edge where in_valid && in_ready && !flush.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL: mult-class op.
  - IDLE→DIV: DIV/DIVU with b≠0.
  - IDLE→DONE: MTHI/MTLO, or divide with b=0.
  - MUL→DONE after MUL_LAT cycles.
  - DIV→DONE after 32 cycles.
  - DONE→IDLE always.
- MTHI/MTLO: HI (or LO) ← in_a at the accept edge.
- MULT/MULTU: {HI,LO} ← 64-bit signed/unsigned product.
- MUL: mul_res ← product[31:0]; HI/LO unchanged.
- MADD(U)/MSUB(U): {HI,LO} ← {HI,LO} ± product, modulo 2^64, signedness per op. Uses the HI/LO value at the accept edge.
- DIV/DIVU: LO ← quotient, HI ← remainder.
  - Signed division runs on magnitudes. Quotient negated if a[31]^b[31]; remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - b=0: HI/LO unchanged; done still pulses.
- Any other op (including MFHI/MFLO and non-MDU ops): accepted, no state change, no done. MFHI/MFLO read the `hi`/`lo` outputs directly.
- flush in any state: next state IDLE, no HI/LO write, no done, in-flight result discarded. flush wins over a same-cycle accept and over a same-cycle completion.
- Operands are latched at accept; in_a/in_b may change afterwards.

## Timing
- Reset values: state IDLE, hi=0, lo=0, done=0, unsup=0, mul_res=0, busy=0, in_ready=1.
- HI/LO are written on the edge that enters DONE. `done` is high for the single DONE cycle, and `hi`/`lo` already show the new values in that cycle.
- Accept-to-done latency:
  - MTHI/MTLO and divide-by-zero: 1 cycle.
  - Mult-class ops: MUL_LAT+1 cycles.
  - DIV/DIVU: 33 cycles.
- in_ready is low from the accept edge through DONE. The earliest back-to-back accept is the cycle after DONE.
- unsup is asserted in the cycle after accept. The FSM stays in IDLE.
- Reset mid-operation has the same effect as flush, and additionally clears HI/LO.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU are executed as above.
- MDU_MADD_EN undefined:
  - The accumulate adder is not built.
  - Those four ops are accepted, and unsup pulses the cycle after accept.
  - HI/LO are unchanged and done is not asserted.

## Structure
- Shared header (mycpu.svh):
  - `mdu_state_t` enum (IDLE, MUL, DIV, DONE).
  - `DIV_STEPS` = 32 constant.
  - `op_t` already lives there.
- Sub-module `mdu_div`: restoring radix-2 divider.
  - Ports: start, a, b, is_signed, kill, busy, q, r, valid.
  - Sign fix-up is done internally.
  - Completes exactly 32 cycles after start.
- The multiplier is an inline MUL_LAT-deep registered product pipeline with a valid shift-register. kill clears the valid bits.

## Test plan
- MULT a=0xFFFFFFFF, b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE; done exactly 4 cycles after accept. MULTU, same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, done at accept+33. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU with b=0 after MTLO 0x1234 → done at accept+1, LO=0x1234.
- Start DIV, assert flush at accept+10 → IDLE next cycle, no done, HI/LO unchanged. An MTHI 0xA5A5A5A5 presented the following cycle → HI=0xA5A5A5A5 with done at accept+1.
- HI=0, LO=0xFFFFFFFF, then MADDU a=1, b=1 → HI=1, LO=0 (MDU_MADD_EN). Without the macro: unsup pulses one cycle, HI/LO unchanged.
- MUL a=3, b=−5 → mul_res=0xFFFFFFF1 while done is high, HI/LO unchanged. reset asserted mid-MULT → hi=lo=0, done never pulses.
